// File: rtl/glyph_pkg.sv
// Shared constants and FSM state type for the glyph blitter.
// Imported by the blitter top level and by its address generator.
package glyph_pkg;

    localparam int GLYPH_W          = 8;
    localparam int GLYPH_H          = 8;
    localparam int SCREEN_W_DEFAULT = 320;
    localparam int SCREEN_H_DEFAULT = 240;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        POP     = 3'd1,
        LATCH   = 3'd2,
        FETCH   = 3'd3,
        ROMWAIT = 3'd4,
        DRAW    = 3'd5
    } state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Combinational pixel-to-framebuffer mapping: bounds test plus linear address.
// This is the only multiplier in the blitter.
module fb_addr_gen
    import glyph_pkg::*;
#(
    parameter int PX_WIDTH      = 10,
    parameter int PY_WIDTH      = 10,
    parameter int SCREEN_W      = SCREEN_W_DEFAULT,
    parameter int SCREEN_H      = SCREEN_H_DEFAULT,
    parameter int FB_ADDR_WIDTH = 17
) (
    input  logic [PX_WIDTH-1:0]      i_px,
    input  logic [PY_WIDTH-1:0]      i_py,
    output logic                     o_inBounds,
    output logic [FB_ADDR_WIDTH-1:0] o_fbAddr
);

    assign o_inBounds = (32'(i_px) < 32'(SCREEN_W)) && (32'(i_py) < 32'(SCREEN_H));
    assign o_fbAddr   = FB_ADDR_WIDTH'(32'(i_py) * 32'(SCREEN_W) + 32'(i_px));

endmodule

// File: rtl/glyph_blitter.sv
// Pops {char,x,y} entries from the character stack and draws each 8x8 glyph,
// fetching one font row at a time and emitting one framebuffer write per pixel.
module glyph_blitter
    import glyph_pkg::*;
#(
    parameter int CHAR_ID_WIDTH = 8,
    parameter int X_WIDTH       = 9,
    parameter int Y_WIDTH       = 9,
    parameter int SCREEN_W      = SCREEN_W_DEFAULT,
    parameter int SCREEN_H      = SCREEN_H_DEFAULT,
    parameter int FB_ADDR_WIDTH = 17,
    parameter int COLOR_WIDTH   = 12,
    parameter int TRANSPARENT   = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     empty,
    output logic                     pop,
    input  logic [CHAR_ID_WIDTH-1:0] char_id_in,
    input  logic [X_WIDTH-1:0]       x_in,
    input  logic [Y_WIDTH-1:0]       y_in,
    input  logic [COLOR_WIDTH-1:0]   fg_color,
    input  logic [COLOR_WIDTH-1:0]   bg_color,
    output logic [CHAR_ID_WIDTH+2:0] rom_addr,
    input  logic [7:0]               rom_data,
    output logic                     fb_we,
    output logic [FB_ADDR_WIDTH-1:0] fb_addr,
    output logic [COLOR_WIDTH-1:0]   fb_data,
    output logic                     busy
);

    localparam int PX_WIDTH = X_WIDTH + 1;
    localparam int PY_WIDTH = Y_WIDTH + 1;

    state_t                   r_state;
    state_t                   w_nextState;
    logic [CHAR_ID_WIDTH-1:0] r_char;
    logic [X_WIDTH-1:0]       r_x;
    logic [Y_WIDTH-1:0]       r_y;
    logic [2:0]               r_row;
    logic [2:0]               r_col;
    logic [7:0]               r_rowBits;
    logic [CHAR_ID_WIDTH+2:0] r_romAddr;
    logic                     r_fbWe;
    logic [FB_ADDR_WIDTH-1:0] r_fbAddr;
    logic [COLOR_WIDTH-1:0]   r_fbData;

    logic                     w_lastCol;
    logic                     w_lastRow;
    logic                     w_pixValid;
    logic [2:0]               w_pixCol;
    logic [7:0]               w_pixBits;
    logic                     w_pixOn;
    logic [PX_WIDTH-1:0]      w_px;
    logic [PY_WIDTH-1:0]      w_py;
    logic                     w_inBounds;
    logic [FB_ADDR_WIDTH-1:0] w_fbAddr;

    assign w_lastCol = (r_col == 3'd7);
    assign w_lastRow = (r_row == 3'd7);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        pop         = 1'b0;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE:    if (enable && !empty) w_nextState = POP;
            POP: begin
                pop         = 1'b1;
                w_nextState = LATCH;
            end
            LATCH:   w_nextState = FETCH;
            FETCH:   w_nextState = ROMWAIT;
            ROMWAIT: w_nextState = DRAW;
            DRAW:    if (w_lastCol) w_nextState = w_lastRow ? IDLE : FETCH;
            default: w_nextState = IDLE;
        endcase
    end

    // The ROM address is loaded one state ahead so it is stable throughout FETCH and ROMWAIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_char    <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_row     <= 3'd0;
            r_col     <= 3'd0;
            r_rowBits <= 8'd0;
            r_romAddr <= '0;
        end else begin
            case (r_state)
                LATCH: begin
                    r_char    <= char_id_in;
                    r_x       <= x_in;
                    r_y       <= y_in;
                    r_row     <= 3'd0;
                    r_romAddr <= {char_id_in, 3'd0};
                end
                ROMWAIT: begin
                    r_rowBits <= rom_data;
                    r_col     <= 3'd0;
                end
                DRAW: begin
                    r_col <= r_col + 3'd1;
                    if (w_lastCol && !w_lastRow) begin
                        r_row     <= r_row + 3'd1;
                        r_romAddr <= {r_char, r_row + 3'd1};
                    end
                end
                default: ;
            endcase
        end
    end

    // Select the pixel that will be on the fb port next cycle, so DRAW col k shows pixel k.
    always_comb begin
        w_pixValid = 1'b0;
        w_pixCol   = r_col + 3'd1;
        w_pixBits  = r_rowBits;
        if (r_state == ROMWAIT) begin
            w_pixValid = 1'b1;
            w_pixCol   = 3'd0;
            w_pixBits  = rom_data;
        end else if ((r_state == DRAW) && !w_lastCol) begin
            w_pixValid = 1'b1;
        end
    end

    assign w_pixOn = w_pixBits[3'd7 - w_pixCol];
    assign w_px    = PX_WIDTH'(r_x) + PX_WIDTH'(w_pixCol);
    assign w_py    = PY_WIDTH'(r_y) + PY_WIDTH'(r_row);

    fb_addr_gen #(
        .PX_WIDTH      (PX_WIDTH),
        .PY_WIDTH      (PY_WIDTH),
        .SCREEN_W      (SCREEN_W),
        .SCREEN_H      (SCREEN_H),
        .FB_ADDR_WIDTH (FB_ADDR_WIDTH)
    ) u_addrGen (
        .i_px       (w_px),
        .i_py       (w_py),
        .o_inBounds (w_inBounds),
        .o_fbAddr   (w_fbAddr)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fbWe   <= 1'b0;
            r_fbAddr <= '0;
            r_fbData <= '0;
        end else begin
            r_fbWe <= w_pixValid && w_inBounds && (w_pixOn || (TRANSPARENT == 0));
            if (w_pixValid) begin
                r_fbAddr <= w_fbAddr;
                r_fbData <= w_pixOn ? fg_color : bg_color;
            end
        end
    end

    assign rom_addr = r_romAddr;
    assign fb_we    = r_fbWe;
    assign fb_addr  = r_fbAddr;
    assign fb_data  = r_fbData;

endmodule

// File: tb/tb_glyph_blitter.sv
// Self-checking bench: a stack and font ROM model feed two blitters (transparent and
// opaque); every write is checked against a per-glyph pixel list built from the drawing rules.
module tb_glyph_blitter;

    typedef struct { logic [7:0] id; logic [8:0] x; logic [8:0] y; } entry_t;
    typedef struct { int addr; logic [11:0] data; } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        empty = 1'b1;
    logic [7:0]  char_id_in = 8'd0;
    logic [8:0]  x_in = 9'd0;
    logic [8:0]  y_in = 9'd0;
    logic [11:0] fg_color = 12'hF80;
    logic [11:0] bg_color = 12'h00F;
    logic [7:0]  rom_data = 8'd0;

    logic        popT, popO, weT, weO, busyT, busyO;
    logic [10:0] romAddrT, romAddrO;
    logic [16:0] addrT, addrO;
    logic [11:0] dataT, dataO;

    entry_t      stackQ[$];
    wr_t         expT[$];
    wr_t         expO[$];
    int          popTimes[$];
    logic [7:0]  font [0:255][0:7];

    int checks = 0, failures = 0;
    int cycleCount = 0;
    int popCnt = 0, busyCnt = 0, wrCntT = 0, wrCntO = 0, bgCntO = 0;
    int firstAddrT = -1, lastAddrT = -1;

    glyph_blitter #(.TRANSPARENT(1)) dutT (
        .clock(clock), .reset(reset), .enable(enable), .empty(empty), .pop(popT),
        .char_id_in(char_id_in), .x_in(x_in), .y_in(y_in),
        .fg_color(fg_color), .bg_color(bg_color),
        .rom_addr(romAddrT), .rom_data(rom_data),
        .fb_we(weT), .fb_addr(addrT), .fb_data(dataT), .busy(busyT)
    );

    glyph_blitter #(.TRANSPARENT(0)) dutO (
        .clock(clock), .reset(reset), .enable(enable), .empty(empty), .pop(popO),
        .char_id_in(char_id_in), .x_in(x_in), .y_in(y_in),
        .fg_color(fg_color), .bg_color(bg_color),
        .rom_addr(romAddrO), .rom_data(rom_data),
        .fb_we(weO), .fb_addr(addrO), .fb_data(dataO), .busy(busyO)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] id, input logic [8:0] x, input logic [8:0] y);
        entry_t e;
        e.id = id;
        e.x  = x;
        e.y  = y;
        stackQ.push_back(e);
    endtask

    // Every pixel of the glyph, row-major, keeping only on-screen ones.
    task automatic buildExpected(input entry_t e);
        int  px, py;
        bit  on;
        wr_t w;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                px     = int'(e.x) + c;
                py     = int'(e.y) + r;
                on     = font[e.id][r][7-c];
                w.addr = py * 320 + px;
                w.data = on ? fg_color : bg_color;
                if (px < 320 && py < 240) begin
                    if (on) expT.push_back(w);
                    expO.push_back(w);
                end
            end
        end
    endtask

    task automatic clearCounts();
        popCnt = 0; busyCnt = 0; wrCntT = 0; wrCntO = 0; bgCntO = 0;
        firstAddrT = -1; lastAddrT = -1;
        popTimes.delete();
    endtask

    task automatic runUntilIdle(input int budget);
        int n;
        n = 0;
        @(negedge clock);
        while ((busyT || stackQ.size() != 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (n >= budget) checkOutput("idle_timeout", int'(busyT || stackQ.size() != 0), 0);
        repeat (2) @(negedge clock);
        checkOutput("T_pending_writes", expT.size(), 0);
        checkOutput("O_pending_writes", expO.size(), 0);
    endtask

    // Stack and synchronous font ROM model.
    always @(negedge clock) begin
        entry_t e;
        if (!reset && popT) begin
            popCnt++;
            if (stackQ.size() == 0) begin
                checkOutput("pop_on_empty", int'(popT), 0);
            end else begin
                e = stackQ.pop_front();
                char_id_in = e.id;
                x_in       = e.x;
                y_in       = e.y;
                buildExpected(e);
                popTimes.push_back(cycleCount);
            end
        end
        empty    = (stackQ.size() == 0);
        rom_data = font[romAddrT[10:3]][romAddrT[2:0]];
    end

    // Per-cycle comparison of both write ports against the expected pixel lists.
    always @(negedge clock) begin
        wr_t w;
        if (!reset) begin
            if (busyT) busyCnt++;
            if (!busyT) checkOutput("T_we_while_idle", int'(weT), 0);
            if (weT) begin
                if (expT.size() == 0) begin
                    checkOutput("T_unexpected_we", int'(weT), 0);
                end else begin
                    w = expT.pop_front();
                    checkOutput("T_addr", int'(addrT), w.addr);
                    checkOutput("T_data", int'(dataT), int'(w.data));
                end
                if (wrCntT == 0) firstAddrT = int'(addrT);
                lastAddrT = int'(addrT);
                wrCntT++;
            end
            if (weO) begin
                if (expO.size() == 0) begin
                    checkOutput("O_unexpected_we", int'(weO), 0);
                end else begin
                    w = expO.pop_front();
                    checkOutput("O_addr", int'(addrO), w.addr);
                    checkOutput("O_data", int'(dataO), int'(w.data));
                end
                if (dataO == bg_color) bgCntO++;
                wrCntO++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout actual=%0d expected=0", cycleCount);
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        int nPop, nWe, nBusy, n;
        for (int i = 0; i < 256; i++)
            for (int r = 0; r < 8; r++) font[i][r] = 8'h00;
        for (int r = 0; r < 8; r++) begin
            font[8'h41][r] = 8'hFF;
            font[8'h42][r] = 8'h81;
        end

        $display("[TB] reset values");
        repeat (3) @(negedge clock);
        checkOutput("rst_pop", int'(popT), 0);
        checkOutput("rst_fb_we", int'(weT), 0);
        checkOutput("rst_fb_addr", int'(addrT), 0);
        checkOutput("rst_fb_data", int'(dataT), 0);
        checkOutput("rst_rom_addr", int'(romAddrT), 0);
        checkOutput("rst_busy", int'(busyT), 0);
        reset = 1'b0;

        $display("[TB] idle with empty stack");
        nPop = 0; nWe = 0; nBusy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (popT) nPop++;
            if (weT || weO) nWe++;
            if (busyT) nBusy++;
        end
        checkOutput("idle_pops", nPop, 0);
        checkOutput("idle_writes", nWe, 0);
        checkOutput("idle_busy", nBusy, 0);

        $display("[TB] single solid glyph");
        clearCounts();
        applyStimulus(8'h41, 9'd10, 9'd20);
        runUntilIdle(300);
        checkOutput("solid_pops", popCnt, 1);
        checkOutput("solid_writes_T", wrCntT, 64);
        checkOutput("solid_writes_O", wrCntO, 64);
        checkOutput("solid_first_addr", firstAddrT, 6410);
        checkOutput("solid_last_addr", lastAddrT, 8657);
        checkOutput("solid_busy_cycles", busyCnt, 82);

        $display("[TB] 0x81 row pattern");
        clearCounts();
        applyStimulus(8'h42, 9'd40, 9'd50);
        runUntilIdle(300);
        checkOutput("edge_writes_T", wrCntT, 16);
        checkOutput("edge_writes_O", wrCntO, 64);
        checkOutput("edge_bg_writes_O", bgCntO, 48);

        $display("[TB] clipping at bottom-right corner");
        clearCounts();
        applyStimulus(8'h41, 9'd316, 9'd236);
        runUntilIdle(300);
        checkOutput("clip_writes_T", wrCntT, 16);
        checkOutput("clip_first_addr", firstAddrT, 75836);
        checkOutput("clip_last_addr", lastAddrT, 76799);

        $display("[TB] fully off-screen glyph");
        clearCounts();
        applyStimulus(8'h41, 9'd400, 9'd10);
        runUntilIdle(300);
        checkOutput("off_pops", popCnt, 1);
        checkOutput("off_writes_T", wrCntT, 0);
        checkOutput("off_writes_O", wrCntO, 0);
        checkOutput("off_busy_cycles", busyCnt, 82);

        $display("[TB] three back-to-back glyphs");
        clearCounts();
        applyStimulus(8'h41, 9'd10, 9'd20);
        applyStimulus(8'h41, 9'd100, 9'd100);
        applyStimulus(8'h41, 9'd200, 9'd50);
        runUntilIdle(600);
        checkOutput("b2b_pops", popCnt, 3);
        checkOutput("b2b_writes_T", wrCntT, 192);
        if (popTimes.size() == 3) begin
            checkOutput("b2b_spacing_1", popTimes[1] - popTimes[0], 83);
            checkOutput("b2b_spacing_2", popTimes[2] - popTimes[1], 83);
        end else begin
            checkOutput("b2b_pop_times", popTimes.size(), 3);
        end

        $display("[TB] enable dropped during second glyph");
        clearCounts();
        applyStimulus(8'h41, 9'd10, 9'd20);
        applyStimulus(8'h41, 9'd100, 9'd100);
        applyStimulus(8'h41, 9'd200, 9'd50);
        n = 0;
        while (popCnt < 2 && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) checkOutput("second_pop_timeout", popCnt, 2);
        repeat (20) @(negedge clock);
        enable = 1'b0;
        n = 0;
        while (busyT && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) checkOutput("drain_timeout", int'(busyT), 0);
        repeat (10) @(negedge clock);
        checkOutput("drop_pops", popCnt, 2);
        checkOutput("drop_writes_T", wrCntT, 128);
        checkOutput("drop_stack_left", stackQ.size(), 1);
        checkOutput("drop_pending_T", expT.size(), 0);
        stackQ.delete();
        @(negedge clock);
        enable = 1'b1;

        $display("[TB] reset in the middle of a glyph");
        clearCounts();
        applyStimulus(8'h41, 9'd10, 9'd20);
        n = 0;
        while (!popT && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) checkOutput("pop_wait_timeout", int'(popT), 1);
        repeat (38) @(negedge clock);
        checkOutput("mid_fb_we", int'(weT), 1);
        checkOutput("mid_fb_addr", int'(addrT), 7374);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midrst_fb_we", int'(weT), 0);
        checkOutput("midrst_busy", int'(busyT), 0);
        checkOutput("midrst_pop", int'(popT), 0);
        reset = 1'b0;
        expT.delete();
        expO.delete();
        @(negedge clock);
        clearCounts();
        applyStimulus(8'h42, 9'd30, 9'd30);
        runUntilIdle(300);
        checkOutput("after_rst_pops", popCnt, 1);
        checkOutput("after_rst_writes_T", wrCntT, 16);
        checkOutput("after_rst_writes_O", wrCntO, 64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
